// File: rtl/bootdata_pkg.sv
// Shared constants for the host-to-bootloader word interface: state encoding,
// padding byte and the lane-order rule (first byte of a word lands in the MSB lane).
package bootdata_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned LANE_W     = 2;
  localparam logic [7:0]  PAD_BYTE   = 8'hFF;
  localparam logic [31:0] PAD_WORD   = {4{PAD_BYTE}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HRST    = 3'd1,
    ST_FILL    = 3'd2,
    ST_REQ     = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DONE    = 3'd5,
    ST_TIMEOUT = 3'd6
  } state_t;

  // Lane index 0 is the first byte of a word and maps to bits [31:24].
  function automatic logic [31:0] place_byte(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  data);
    logic [31:0] w;
    w = word;
    case (lane)
      2'd0:    w[31:24] = data;
      2'd1:    w[23:16] = data;
      2'd2:    w[15:8]  = data;
      default: w[7:0]   = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/bootdata_sender_packer.sv
// Byte-to-word assembler: fills lanes MSB first, pre-padded with PAD_BYTE so a
// word flushed early by 'last' carries padding in its unfilled lanes.
module bootdata_packer
  import bootdata_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              last,
  input  logic [BYTE_W-1:0] data,
  output logic [WORD_W-1:0] word_next_c,
  output logic              word_done_c
);

  logic [WORD_W-1:0] word_q;
  logic [LANE_W-1:0] lane_q;

  assign word_next_c = place_byte(word_q, lane_q, data);
  assign word_done_c = load && ((lane_q == 2'd3) || last);

  // Completed words hand off to the sender, so the assembler restarts padded.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word_q <= PAD_WORD;
      lane_q <= '0;
    end else if (load) begin
      if (word_done_c) begin
        word_q <= PAD_WORD;
        lane_q <= '0;
      end else begin
        word_q <= word_next_c;
        lane_q <= lane_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/bootdata_sender.sv
// Host-side boot image sender: pulses host_reset, then streams the image as
// 32-bit words over a four-phase req/ack handshake with an ack timeout.
module bootdata_sender
  import bootdata_pkg::*;
#(
  parameter int unsigned IMAGE_BYTES = 49152,
  parameter int unsigned RST_CYCLES  = 16,
  parameter int unsigned ACK_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              host_reset,
  output logic [WORD_W-1:0] host_bootdata,
  output logic              host_bootdata_req,
  input  logic              host_bootdata_ack,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  localparam int unsigned CNT_W     = $clog2(IMAGE_BYTES + 1);
  localparam int unsigned TIMER_MAX = (ACK_TIMEOUT > RST_CYCLES) ? ACK_TIMEOUT : RST_CYCLES;
  localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [WORD_W-1:0]  data_d;
  logic [WORD_W-1:0]  word_next_c;
  logic               word_done_c;
  logic               accept;
  logic               last_byte;
  logic               pack_clear;

  assign accept    = byte_valid && byte_ready && (state_q == ST_FILL);
  assign last_byte = (cnt_q == CNT_W'(IMAGE_BYTES - 1));

  bootdata_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear       (pack_clear),
    .load        (accept),
    .last        (last_byte),
    .data        (byte_data),
    .word_next_c (word_next_c),
    .word_done_c (word_done_c)
  );

  // State register; every output is registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      cnt_q             <= '0;
      timer_q           <= '0;
      host_bootdata     <= '0;
      host_bootdata_req <= 1'b0;
      host_reset        <= 1'b0;
      byte_ready        <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      timeout_err       <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      timer_q           <= timer_d;
      host_bootdata     <= data_d;
      host_bootdata_req <= (state_d == ST_REQ);
      host_reset        <= (state_d == ST_HRST);
      byte_ready        <= (state_d == ST_FILL);
      busy              <= (state_d inside {ST_HRST, ST_FILL, ST_REQ, ST_RELEASE});
      done              <= (state_d == ST_DONE);
      timeout_err       <= (state_d == ST_TIMEOUT);
    end
  end

  // Next-state logic; one timer serves the reset pulse and both ack waits.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    data_d     = host_bootdata;
    pack_clear = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (start) begin
          state_d    = ST_HRST;
          cnt_d      = '0;
          timer_d    = '0;
          data_d     = '0;
          pack_clear = 1'b1;
        end
      end
      ST_HRST: begin
        if (timer_q == TIMER_W'(RST_CYCLES - 1)) begin
          state_d = ST_FILL;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_FILL: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (word_done_c) begin
            state_d = ST_REQ;
            data_d  = word_next_c;
            timer_d = '0;
          end
        end
      end
      ST_REQ: begin
        if (host_bootdata_ack) begin
          state_d = ST_RELEASE;
          timer_d = '0;
        end else if (timer_q == TIMER_W'(ACK_TIMEOUT - 1)) begin
          state_d = ST_TIMEOUT;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!host_bootdata_ack) begin
          timer_d = '0;
          state_d = (cnt_q == CNT_W'(IMAGE_BYTES)) ? ST_DONE : ST_FILL;
        end else if (timer_q == TIMER_W'(ACK_TIMEOUT - 1)) begin
          state_d = ST_TIMEOUT;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/bootdata_sender.md
Name: bootdata_sender

Overview:
- Host-side transmitter feeding the ROM bootloader in the CPC memory manager over the host_bootdata / req / ack word interface.
- Accepts a byte stream from the control module's image source (SD or flash reader) and packs it into 32-bit words.
- Presents each word with a req/ack handshake and stops after a fixed image length.
- Also drives the bootloader's host-reset pulse, so a reload always starts at the ROM base address.

Parameters:
- IMAGE_BYTES, 49152: bytes per image (OS + BASIC + AMSDOS, 3 x 16 KB); need not be a multiple of 4.
- RST_CYCLES, 16: length in clk cycles of the host_reset pulse issued at start.
- ACK_TIMEOUT, 65535: max cycles to wait for ack (or ack release) before aborting.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a transfer (ignored unless IDLE, DONE or TIMEOUT)
- byte_data  in  8  next image byte from source
- byte_valid  in  1  byte_data valid
- byte_ready  out  1  byte consumed this cycle when byte_valid && byte_ready
- host_reset  out  1  reset to bootloader, active-high
- host_bootdata  out  32  packed word
- host_bootdata_req  out  1  word valid / request
- host_bootdata_ack  in  1  bootloader accepted word
- busy  out  1  transfer in progress
- done  out  1  level; full image delivered
- timeout_err  out  1  level; ack handshake timed out

Behaviour:
- Reset values: all outputs 0; host_bootdata = 32'h0; state IDLE; byte counter and timer cleared.
- Reset mid-transfer forces IDLE on the next edge. Req drops immediately; no partial word is resumed.
- States: IDLE, HRST, FILL, REQ, RELEASE, DONE, TIMEOUT.
- IDLE/DONE/TIMEOUT, on start:
  - Go to HRST.
  - Clear done, timeout_err, byte counter and lane index.
  - Set busy = 1.
- HRST:
  - host_reset = 1 for exactly RST_CYCLES cycles, then 0, then go to FILL.
  - byte_ready = 0 throughout.
- FILL:
  - byte_ready = 1.
  - Each accepted byte goes into lane (3 - lane index): first byte of a word in [31:24], fourth byte in [7:0].
  - The byte counter increments per accepted byte.
  - Go to REQ when 4 bytes are accepted, or when the byte counter reaches IMAGE_BYTES with a partial word.
  - Unfilled lanes of a partial final word are padded with 8'hFF.
  - No byte is accepted in the same cycle the transition to REQ occurs beyond the 4th / last byte.
- REQ:
  - host_bootdata_req = 1; host_bootdata held stable; byte_ready = 0; timer counts.
  - On host_bootdata_ack = 1: req drops on the next edge, go to RELEASE.
  - Timer reaching ACK_TIMEOUT: go to TIMEOUT.
- RELEASE (four-phase):
  - Wait for ack = 0, with timer restarted.
  - Then, if byte counter == IMAGE_BYTES, go to DONE; else clear lane index and go to FILL.
  - Minimum req-low time is 1 cycle between words.
  - Ack stuck high past ACK_TIMEOUT: go to TIMEOUT.
- DONE: done = 1, busy = 0.
- TIMEOUT: timeout_err = 1, busy = 0, req = 0.
- Latency:
  - Word N's req rises the cycle after its last byte is accepted.
  - With zero-wait source and an ack that responds next cycle and releases next cycle, throughput is 1 word per 8 cycles minimum; this is not required to be better.
- Counter width: $clog2(IMAGE_BYTES+1). Comparisons are exact; no wrap.
- start while busy is ignored.
- byte_valid gaps in FILL just stall.
- Ack asserted outside REQ is ignored.

Decomposition:
- Shared package: state encoding constants, PAD_BYTE = 8'hFF, and the lane-order rule (first byte in MSB lane). The bootloader side uses the same constants.
- Sub-module: bootdata_packer (byte-to-word assembler with lane index, padding, and a flush-on-last input).
- The FSM and timers stay in the top module.

Test Plan:
- IMAGE_BYTES=8, RST_CYCLES=4, source bytes 01..08, ack one cycle after req and released next cycle:
  - host_reset high exactly 4 cycles.
  - Words 32'h01020304 then 32'h05060708.
  - done=1, busy=0, exactly 8 bytes consumed.
- IMAGE_BYTES=6, bytes AA BB CC DD EE 11:
  - Second word is 32'h EE11FFFF.
  - done asserted after its handshake.
- Ack withheld, ACK_TIMEOUT=20:
  - Req held with stable data for 20 cycles, then req=0 and timeout_err=1.
  - A fresh start clears timeout_err and replays from byte 0.
- Ack held high after its pulse for 5 cycles:
  - Sender stays in RELEASE.
  - Next req rises no earlier than 1 cycle after ack falls.
- Random byte_valid gaps and random 0-10 cycle ack delay, IMAGE_BYTES=64:
  - Word stream equals the big-endian packing of the input.
  - Host_bootdata never changes while req=1.
- reset pulse during word 3's REQ:
  - All outputs 0 next cycle.
  - start then redoes the full host_reset pulse and resends from word 0.
